branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor branch unit for the fcpu out-of-order core. It resolves conditional branches and jumps from a filled reservation-station entry and broadcasts the result on the CDB. Per ROB tag it keeps the predicted and resolved outcome and flags a mispredict at commit. It also owns a PC-indexed table of 2-bit saturating counters. That table supplies the scheduler's take prediction, replacing the old hard-wired not-taken flag, and trains at commit.

Parameters:
DATA_W, 32, operand/result width
INSTR_W, 6, opcode width (fcpu_pkg)
TAG_W, 3, ROB tag width; 2**TAG_W tracked branches
PC_W, 16, program counter width
BHT_W, 6, log2 of history-table entries (BHT_W <= PC_W)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
clear  in  1  synchronous flush (mispredict recovery)
disp_valid  in  1  branch dispatched this cycle
disp_tag  in  TAG_W  ROB tag of dispatched branch
disp_pred  in  1  prediction used by fetch for it
x_valid  in  1  filled branch op available
x_ready  out  1  unit accepts op
x_tag  in  TAG_W  op ROB tag
x_opcode  in  INSTR_W  branch opcode
x_a1, x_a2  in  DATA_W  compare operands
x_dst  in  DATA_W  link/target value placed on CDB
o_cdb  out  TAG_W+DATA_W  {tag, dst}
o_valid  out  1  CDB request
o_ready  in  1  CDB grant
pred_pc  in  PC_W  fetch PC for prediction
pred_take  out  1  predicted taken
commit_valid  in  1  ROB committing head
commit_tag  in  TAG_W  head tag
commit_opcode  in  INSTR_W  head opcode
commit_pc  in  PC_W  head PC (training index)
pred_condition  out  1  stored prediction of commit_tag
true_condition  out  1  resolved outcome of commit_tag
pred_miss  out  1  mispredict at commit
commit_err  out  1  conditional branch committed unresolved

Behaviour:
- Reset (nrst low, async): o_valid=0, o_cdb=0, all pred/true/resolved bits 0, every BHT counter 2'b01 (weakly not-taken). commit_err=0.
- Conditions: BEQ a1==a2; BNE a1!=a2; BLT/BGE signed; BLTU/BGEU unsigned; JMP/JMPR always true. Any other opcode: forwarded to the CDB, state untouched.
- Exec path: one output register stage. x_ready = ~o_valid | o_ready. On x_valid&x_ready:
  - o_cdb <= {x_tag, x_dst}; o_valid <= 1.
  - true[x_tag] <= cond; resolved[x_tag] <= 1.
  - Latency: 1 cycle accept-to-o_valid.
  - o_valid&o_ready with no new accept clears o_valid.
  - o_cdb holds stable while o_valid&~o_ready.
- Dispatch: disp_valid writes pred[disp_tag] <= disp_pred and resolved[disp_tag] <= 0. The same tag accepted by exec in the same cycle cannot legally occur; if it does, dispatch wins.
- Commit (combinational from current state):
  - pred_condition = pred[commit_tag].
  - true_condition = resolved value, bypassed from the exec write when x_tag==commit_tag in the same cycle.
  - pred_miss = commit_valid & (JMPR ? 1 : conditional ? true^pred : 0). JMP never misses.
  - commit_err = commit_valid & conditional & ~resolved (after bypass); pred_miss is then 0.
- Prediction: pred_take = bht[pred_pc[BHT_W-1:0]][1], combinational.
- Training: at commit_valid of a conditional branch (not erroring), bht[commit_pc[BHT_W-1:0]] increments if true_condition, else decrements. Saturates at 3 and 0. Training takes effect next cycle; a same-cycle read returns the old value.
- clear: synchronously zeroes o_valid and resolved/pred bits, and forces x_ready to 0 for that cycle. BHT contents are retained. clear takes priority over dispatch, exec and commit writes; pred_miss/commit_err are still computed that cycle.
- Reset mid-operation: async; the in-flight CDB result is dropped.

Decomposition:
- fcpu_pkg gains I_BNE, I_BGE, I_BLTU, I_BGEU opcodes, a branch_cond function (opcode, a1, a2 -> bit), and a BHT_INIT constant (2'b01).
- One sub-module: branch_history_table, with the counter array, read port, saturating update port and async reset.
- The reservation station stays external; this unit consumes its filled output.

Test Plan:
- Reset, then pred_pc=0 -> pred_take=0. Dispatch tag 2 pred=0; exec BEQ tag2 a1=5 a2=5 dst=0x40 -> next cycle o_valid=1, o_cdb={2,0x40}. Commit tag2 BEQ -> true_condition=1, pred_miss=1.
- BLT a1=0xFFFFFFFF a2=1 -> true=1; BLTU with the same operands -> true=0. Both committed with pred=1 -> pred_miss=0, then 1.
- o_ready=0 for 3 cycles with a second op pending -> x_ready=0 and o_cdb stable; o_ready=1 -> second result appears the following cycle, no op lost.
- Four taken commits at pc=0x13 -> counter 01→10→11→11, and pred_take for pred_pc=0x13 goes 1 after the first. Three not-taken commits -> 11→10→01→00.
- Commit BNE tag5 with no prior exec -> commit_err=1, pred_miss=0, BHT unchanged. Exec and commit of tag5 in the same cycle -> bypassed, commit_err=0.
- clear with o_valid=1 and tags 1 and 3 resolved -> o_valid=0 next cycle, resolved bits 0, BHT counters unchanged. An async nrst pulse mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: branch opcodes, condition helpers and BHT constants
package branch_resolve_unit_pkg;
  localparam int OPC_W = 6;
  localparam logic [1:0] BHT_INIT = 2'b01;
  localparam logic [OPC_W-1:0] I_ADD  = 6'h01;
  localparam logic [OPC_W-1:0] I_JMP  = 6'h20;
  localparam logic [OPC_W-1:0] I_JMPR = 6'h21;
  localparam logic [OPC_W-1:0] I_BEQ  = 6'h22;
  localparam logic [OPC_W-1:0] I_BNE  = 6'h23;
  localparam logic [OPC_W-1:0] I_BLT  = 6'h24;
  localparam logic [OPC_W-1:0] I_BGE  = 6'h25;
  localparam logic [OPC_W-1:0] I_BLTU = 6'h26;
  localparam logic [OPC_W-1:0] I_BGEU = 6'h27;

  function automatic logic is_cond(input logic [OPC_W-1:0] op);
    return op inside {I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU};
  endfunction

  function automatic logic is_branch(input logic [OPC_W-1:0] op);
    return is_cond(op) | (op == I_JMP) | (op == I_JMPR);
  endfunction

  // eq/lt/ltu are the operand comparisons, computed at the caller's data width
  function automatic logic branch_cond(input logic [OPC_W-1:0] op, input logic eq, input logic lt, input logic ltu);
    return op == I_BEQ  ? eq :
           op == I_BNE  ? ~eq :
           op == I_BLT  ? lt :
           op == I_BGE  ? ~lt :
           op == I_BLTU ? ltu :
           op == I_BGEU ? ~ltu :
           (op == I_JMP) | (op == I_JMPR);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: filled-op input handshake and CDB output handshake
interface branch_resolve_unit_if #(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 6,
  parameter int TAG_W   = 3
);
  logic                    x_valid;
  logic                    x_ready;
  logic [TAG_W-1:0]        x_tag;
  logic [INSTR_W-1:0]      x_opcode;
  logic [DATA_W-1:0]       x_a1;
  logic [DATA_W-1:0]       x_a2;
  logic [DATA_W-1:0]       x_dst;
  logic [TAG_W+DATA_W-1:0] o_cdb;
  logic                    o_valid;
  logic                    o_ready;
  modport master (output x_valid, x_tag, x_opcode, x_a1, x_a2, x_dst, o_ready, input x_ready, o_cdb, o_valid);
  modport slave  (input x_valid, x_tag, x_opcode, x_a1, x_a2, x_dst, o_ready, output x_ready, o_cdb, o_valid);
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// branch_history_table: PC-indexed 2-bit saturating counters with one read and one update port
module branch_history_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int BHT_W = 6
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [BHT_W-1:0] rd_idx,
  output logic             rd_take,
  input  logic             upd_en,
  input  logic [BHT_W-1:0] upd_idx,
  input  logic             upd_inc
);
  logic [1:0] cnt [2**BHT_W];

  assign rd_take = cnt[rd_idx][1];

  // saturating train; reads in the same cycle still see the old counter
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2**BHT_W; i++) cnt[i] <= BHT_INIT;
    end else if (upd_en) begin
      cnt[upd_idx] <= upd_inc ? (cnt[upd_idx] == 2'd3 ? 2'd3 : cnt[upd_idx] + 2'd1)
                              : (cnt[upd_idx] == 2'd0 ? 2'd0 : cnt[upd_idx] - 2'd1);
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches to the CDB, tracks per-tag outcome, predicts via BHT
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = OPC_W,
  parameter int TAG_W   = 3,
  parameter int PC_W    = 16,
  parameter int BHT_W   = 6
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               disp_valid,
  input  logic [TAG_W-1:0]   disp_tag,
  input  logic               disp_pred,
  branch_resolve_unit_if.slave xb,
  input  logic [PC_W-1:0]    pred_pc,
  output logic               pred_take,
  input  logic               commit_valid,
  input  logic [TAG_W-1:0]   commit_tag,
  input  logic [INSTR_W-1:0] commit_opcode,
  input  logic [PC_W-1:0]    commit_pc,
  output logic               pred_condition,
  output logic               true_condition,
  output logic               pred_miss,
  output logic               commit_err
);
  localparam int NT = 2**TAG_W;

  logic [NT-1:0] pred_r, true_r, res_r;
  logic          acc, x_br, x_cond, byp, c_cond, c_res;

  assign xb.x_ready = ~clear & (~xb.o_valid | xb.o_ready);
  assign acc    = xb.x_valid & xb.x_ready;
  assign x_br   = is_branch(xb.x_opcode);
  assign x_cond = branch_cond(xb.x_opcode, xb.x_a1 == xb.x_a2,
                              $signed(xb.x_a1) < $signed(xb.x_a2), xb.x_a1 < xb.x_a2);

  // exec result forwarded to commit when it resolves the committing tag this cycle
  assign byp            = acc & x_br & (xb.x_tag == commit_tag);
  assign c_cond         = is_cond(commit_opcode);
  assign c_res          = byp | res_r[commit_tag];
  assign pred_condition = pred_r[commit_tag];
  assign true_condition = byp ? x_cond : true_r[commit_tag];
  assign commit_err     = commit_valid & c_cond & ~c_res;
  assign pred_miss      = commit_valid & ((commit_opcode == I_JMPR) |
                          (c_cond & c_res & (true_condition ^ pred_condition)));

  // CDB output stage plus per-tag prediction/outcome bookkeeping; dispatch overrides exec
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      xb.o_valid <= 1'b0;
      xb.o_cdb   <= '0;
      pred_r     <= '0;
      true_r     <= '0;
      res_r      <= '0;
    end else if (clear) begin
      xb.o_valid <= 1'b0;
      pred_r     <= '0;
      res_r      <= '0;
    end else begin
      if (acc) begin
        xb.o_cdb   <= {xb.x_tag, xb.x_dst};
        xb.o_valid <= 1'b1;
      end else if (xb.o_ready) begin
        xb.o_valid <= 1'b0;
      end
      if (acc && x_br) begin
        true_r[xb.x_tag] <= x_cond;
        res_r[xb.x_tag]  <= 1'b1;
      end
      if (disp_valid) begin
        pred_r[disp_tag] <= disp_pred;
        res_r[disp_tag]  <= 1'b0;
      end
    end
  end

  branch_history_table #(.BHT_W(BHT_W)) u_bht (
    .clk     (clk),
    .nrst    (nrst),
    .rd_idx  (pred_pc[BHT_W-1:0]),
    .rd_take (pred_take),
    .upd_en  (commit_valid & c_cond & c_res & ~clear),
    .upd_idx (commit_pc[BHT_W-1:0]),
    .upd_inc (true_condition)
  );
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with a CDB scoreboard and inline commit/predict checks
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;
  localparam int DW = 32;
  localparam int TW = 3;

  logic clk = 0, nrst = 0, clear = 0;
  logic disp_valid = 0, disp_pred = 0;
  logic [TW-1:0] disp_tag = 0, commit_tag = 0;
  logic [15:0] pred_pc = 0, commit_pc = 0;
  logic [5:0] commit_opcode = 0;
  logic commit_valid = 0;
  logic pred_take, pred_condition, true_condition, pred_miss, commit_err;
  int n_cmp = 0, n_bad = 0;
  logic [TW+DW-1:0] sb[$];
  logic [TW+DW-1:0] mon_exp;

  branch_resolve_unit_if #(.DATA_W(DW), .INSTR_W(6), .TAG_W(TW)) bif ();

  branch_resolve_unit dut (
    .clk(clk), .nrst(nrst), .clear(clear),
    .disp_valid(disp_valid), .disp_tag(disp_tag), .disp_pred(disp_pred),
    .xb(bif),
    .pred_pc(pred_pc), .pred_take(pred_take),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_opcode(commit_opcode),
    .commit_pc(commit_pc), .pred_condition(pred_condition), .true_condition(true_condition),
    .pred_miss(pred_miss), .commit_err(commit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; bif.x_valid = 0; commit_valid = 0; clear = 0;
  endtask

  task automatic dispatch(input logic [TW-1:0] t, input logic p);
    disp_valid = 1; disp_tag = t; disp_pred = p;
  endtask

  task automatic exec(input logic [TW-1:0] t, input logic [5:0] op, input logic [DW-1:0] a1, input logic [DW-1:0] a2, input logic [DW-1:0] dst);
    bif.x_valid = 1; bif.x_tag = t; bif.x_opcode = op; bif.x_a1 = a1; bif.x_a2 = a2; bif.x_dst = dst;
    sb.push_back({t, dst});
  endtask

  task automatic commit(input logic [TW-1:0] t, input logic [5:0] op, input logic [15:0] pc);
    commit_valid = 1; commit_tag = t; commit_opcode = op; commit_pc = pc;
  endtask

  // scoreboard monitor: every CDB handshake must match the oldest expected result
  always @(negedge clk) begin
    if (nrst && bif.o_valid && bif.o_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cdb_unexpected: got %0h want none", bif.o_cdb);
      end else begin
        mon_exp = sb.pop_front();
        chk("cdb", bif.o_cdb, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bif.x_valid = 0; bif.x_tag = 0; bif.x_opcode = 0; bif.x_a1 = 0; bif.x_a2 = 0; bif.x_dst = 0;
    bif.o_ready = 1;
    #12 nrst = 1;
    #1;
    chk("rst_o_valid", bif.o_valid, 0);
    chk("rst_o_cdb", bif.o_cdb, 0);
    chk("rst_pred_take", pred_take, 0);
    chk("rst_x_ready", bif.x_ready, 1);
    // BEQ equal operands, predicted not-taken -> mispredict
    tick(); dispatch(2, 0);
    tick(); idle(); exec(2, I_BEQ, 5, 5, 32'h40);
    #1 chk("beq_x_ready", bif.x_ready, 1);
    tick(); idle();
    chk("beq_o_valid", bif.o_valid, 1);
    commit(2, I_BEQ, 16'h5);
    #1;
    chk("beq_true", true_condition, 1);
    chk("beq_pred", pred_condition, 0);
    chk("beq_miss", pred_miss, 1);
    chk("beq_err", commit_err, 0);
    // signed vs unsigned compare of -1 and 1, both predicted taken
    tick(); idle(); dispatch(3, 1);
    tick(); idle(); dispatch(4, 1);
    tick(); idle(); exec(3, I_BLT, 32'hFFFFFFFF, 1, 32'h11);
    tick(); idle(); exec(4, I_BLTU, 32'hFFFFFFFF, 1, 32'h22);
    tick(); idle(); commit(3, I_BLT, 16'h20);
    #1;
    chk("blt_true", true_condition, 1);
    chk("blt_miss", pred_miss, 0);
    tick(); idle(); commit(4, I_BLTU, 16'h21);
    #1;
    chk("bltu_true", true_condition, 0);
    chk("bltu_miss", pred_miss, 1);
    // backpressure: second op held while CDB is not granted
    tick(); idle(); exec(1, I_JMP, 0, 0, 32'h100);
    tick(); idle(); bif.o_ready = 0; exec(6, I_BNE, 1, 2, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_x_ready", bif.x_ready, 0);
      chk("stall_o_cdb", bif.o_cdb, {3'd1, 32'h100});
      tick();
    end
    bif.o_ready = 1;
    #1 chk("unstall_x_ready", bif.x_ready, 1);
    tick(); idle();
    chk("unstall_o_valid", bif.o_valid, 1);
    // BHT training at pc 0x13: taken x4 then not-taken x3
    pred_pc = 16'h13;
    commit(6, I_BNE, 16'h13);
    #1 chk("bht_old_read", pred_take, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bht_up", pred_take, 1);
    end
    commit(4, I_BLTU, 16'h13);
    tick(); chk("bht_dn1", pred_take, 1);
    tick(); chk("bht_dn2", pred_take, 0);
    tick(); chk("bht_dn3", pred_take, 0);
    idle();
    // unresolved commit errors without training; same-cycle exec bypasses
    pred_pc = 16'h5;
    dispatch(5, 0);
    tick(); idle(); commit(5, I_BNE, 16'h5);
    #1;
    chk("unres_err", commit_err, 1);
    chk("unres_miss", pred_miss, 0);
    tick(); idle();
    chk("unres_bht", pred_take, 1);
    exec(5, I_BNE, 3, 4, 32'h55);
    commit(5, I_BNE, 16'h30);
    #1;
    chk("byp_err", commit_err, 0);
    chk("byp_true", true_condition, 1);
    chk("byp_miss", pred_miss, 1);
    // clear drops the held CDB result and resolved bits, keeps the BHT
    tick(); idle(); bif.o_ready = 0; clear = 1;
    #1 chk("clear_x_ready", bif.x_ready, 0);
    tick(); idle();
    void'(sb.pop_front());
    chk("clear_o_valid", bif.o_valid, 0);
    commit(3, I_BLT, 16'h40);
    #1 chk("clear_res3", commit_err, 1);
    tick(); commit(1, I_BNE, 16'h41);
    #1 chk("clear_res1", commit_err, 1);
    chk("clear_bht5", pred_take, 1);
    tick(); idle(); bif.o_ready = 1;
    // async reset with a result in flight
    exec(2, I_JMP, 0, 0, 32'h77);
    tick(); idle(); bif.o_ready = 0;
    #2 nrst = 0;
    #1;
    void'(sb.pop_front());
    chk("arst_o_valid", bif.o_valid, 0);
    chk("arst_o_cdb", bif.o_cdb, 0);
    chk("arst_bht5", pred_take, 0);
    #3 nrst = 1; bif.o_ready = 1;
    // non-branch opcode goes to the CDB but leaves tag state alone
    tick(); exec(3, I_ADD, 1, 1, 32'h99);
    tick(); idle(); commit(3, I_BLT, 16'h50);
    #1 chk("other_err", commit_err, 1);
    tick(); idle();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
